// File: rtl/time_conv_pkg.sv
// Shared widths, FSM encoding and result payload for the time-converter arbiter.
package time_conv_pkg;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned T_W     = 32;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned YEAR_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] hh;
        logic [FIELD_W-1:0] mm;
        logic [FIELD_W-1:0] ss;
        logic [FIELD_W-1:0] dd;
        logic [FIELD_W-1:0] mo;
        logic [YEAR_W-1:0]  yyyy;
    } time_fields_t;

    // One-hot requester vector for a requester index.
    function automatic logic [NREQ-1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/time_conv_arbiter_if.sv
// Request/response bundle between the two requesters and the shared converter.
interface time_conv_arbiter_if;
    import time_conv_pkg::*;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ*T_W-1:0] req_t;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [FIELD_W-1:0]  rsp_hh;
    logic [FIELD_W-1:0]  rsp_mm;
    logic [FIELD_W-1:0]  rsp_ss;
    logic [FIELD_W-1:0]  rsp_DD;
    logic [FIELD_W-1:0]  rsp_MM;
    logic [YEAR_W-1:0]   rsp_YYYY;
    logic                busy;

    modport master (
        output req_valid, req_t, rsp_ready,
        input  req_ready, rsp_valid, rsp_hh, rsp_mm, rsp_ss,
               rsp_DD, rsp_MM, rsp_YYYY, busy
    );

    modport slave (
        input  req_valid, req_t, rsp_ready,
        output req_ready, rsp_valid, rsp_hh, rsp_mm, rsp_ss,
               rsp_DD, rsp_MM, rsp_YYYY, busy
    );

endinterface

// File: rtl/binary_time_converter.sv
// Combinational epoch-seconds to civil UTC time/date (days-from-civil inverse, 1970 origin).
module binary_time_converter (
    input  logic [31:0] t_i,
    output logic [4:0]  hh_o,
    output logic [5:0]  mm_o,
    output logic [5:0]  ss_o,
    output logic [4:0]  dd_o,
    output logic [3:0]  mo_o,
    output logic [11:0] year_o
);

    logic [31:0] sod;
    logic [31:0] days;
    logic [31:0] z;
    logic [31:0] era;
    logic [31:0] doe;
    logic [31:0] yoe;
    logic [31:0] doy;
    logic [31:0] mp;
    logic [31:0] d;
    logic [31:0] m;
    logic [31:0] y;

    // Split into time of day and day count, then walk 400-year eras starting from March 1st
    always_comb begin
        sod    = t_i % 32'd86400;
        days   = t_i / 32'd86400;
        z      = days + 32'd719468;
        era    = z / 32'd146097;
        doe    = z - era * 32'd146097;
        yoe    = (doe - doe / 32'd1460 + doe / 32'd36524 - doe / 32'd146096) / 32'd365;
        doy    = doe - (32'd365 * yoe + yoe / 32'd4 - yoe / 32'd100);
        mp     = (32'd5 * doy + 32'd2) / 32'd153;
        d      = doy - (32'd153 * mp + 32'd2) / 32'd5 + 32'd1;
        m      = (mp < 32'd10) ? mp + 32'd3 : mp - 32'd9;
        y      = yoe + era * 32'd400 + ((m <= 32'd2) ? 32'd1 : 32'd0);
        hh_o   = 5'(sod / 32'd3600);
        mm_o   = 6'((sod % 32'd3600) / 32'd60);
        ss_o   = 6'(sod % 32'd60);
        dd_o   = 5'(d);
        mo_o   = 4'(m);
        year_o = 12'(y);
    end

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    // One-hot grant selection
    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/time_conv_arbiter.sv
// Shares one binary_time_converter between two requesters with round-robin arbitration,
// valid/ready handshakes on both sides and CONV_LAT cycles of converter latency.
module time_conv_arbiter
    import time_conv_pkg::*;
#(
    parameter int unsigned CONV_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    time_conv_arbiter_if.slave  bus
);

    localparam logic [1:0] LAT_INIT = 2'(CONV_LAT - 1);

    state_e          state_q;
    logic [T_W-1:0]  conv_t_q;
    logic            owner_q;
    logic            last_q;
    logic [1:0]      lat_cnt_q;
    logic [1:0]      rsp_valid_q;
    time_fields_t    rsp_q;

    logic [1:0]      grant;
    logic [1:0]      req_ready;
    time_fields_t    conv_fields;
    time_fields_t    cap_fields;

    logic [4:0]      cv_hh;
    logic [5:0]      cv_mm;
    logic [5:0]      cv_ss;
    logic [4:0]      cv_dd;
    logic [3:0]      cv_mo;
    logic [11:0]     cv_year;

    rr_arbiter_2 u_arb (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    binary_time_converter u_conv (
        .t_i    (conv_t_q),
        .hh_o   (cv_hh),
        .mm_o   (cv_mm),
        .ss_o   (cv_ss),
        .dd_o   (cv_dd),
        .mo_o   (cv_mo),
        .year_o (cv_year)
    );

    // Zero-extend converter fields into the result payload
    always_comb begin
        conv_fields      = '0;
        conv_fields.hh   = FIELD_W'(cv_hh);
        conv_fields.mm   = FIELD_W'(cv_mm);
        conv_fields.ss   = FIELD_W'(cv_ss);
        conv_fields.dd   = FIELD_W'(cv_dd);
        conv_fields.mo   = FIELD_W'(cv_mo);
        conv_fields.yyyy = YEAR_W'(cv_year);
    end

    // Optional retiming stages between converter and capture register
    if (CONV_LAT == 1) begin : g_nopipe
        assign cap_fields = conv_fields;
    end else begin : g_pipe
        time_fields_t pipe_q [CONV_LAT-1];

        // Shift converter output through CONV_LAT-1 stages
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(CONV_LAT) - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= conv_fields;
                for (int i = 1; i < int'(CONV_LAT) - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign cap_fields = pipe_q[CONV_LAT-2];
    end

    // Accept strobe is live only in IDLE and is forced low while reset is asserted
    assign req_ready = (state_q == IDLE) ? (grant & {2{rst_n}}) : 2'b00;

    // Arbitration / conversion / response FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            conv_t_q    <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lat_cnt_q   <= '0;
            rsp_valid_q <= '0;
            rsp_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_ready) begin
                        conv_t_q  <= req_ready[1] ? bus.req_t[2*T_W-1:T_W] : bus.req_t[T_W-1:0];
                        owner_q   <= req_ready[1];
                        last_q    <= req_ready[1];
                        lat_cnt_q <= LAT_INIT;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt_q == 2'd0) begin
                        rsp_q       <= cap_fields;
                        rsp_valid_q <= onehot2(owner_q);
                        state_q     <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hh    = rsp_q.hh;
    assign bus.rsp_mm    = rsp_q.mm;
    assign bus.rsp_ss    = rsp_q.ss;
    assign bus.rsp_DD    = rsp_q.dd;
    assign bus.rsp_MM    = rsp_q.mo;
    assign bus.rsp_YYYY  = rsp_q.yyyy;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/time_conv_arbiter.md
Name: time_conv_arbiter

Overview:
- Shares one combinational binary_time_converter (32-bit epoch seconds -> hh, mm, ss, DD, MM, YYYY) between two requesters, e.g. the live RTC display path and the alarm/compare path.
- Arbitrates round-robin and uses valid/ready handshakes on both the request and response sides.
- Adds CONV_LAT register stages after the converter for timing closure.
- Sits between the RTC seconds counter/alarm logic and the display/compare logic.

Parameters:
- NREQ, 2, number of requesters. Fixed at 2; the parameter exists for package consistency only.
- CONV_LAT, 1, number of cycles between driving the converter input and capturing its outputs. Legal range 1-4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_t  in  64  epoch seconds; requester i uses bits [32i+31:32i]
- req_ready  out  2  one-hot accept strobe
- rsp_valid  out  2  one-hot result valid; the set bit identifies the owner
- rsp_ready  in  2  per-requester result accept
- rsp_hh  out  8  hours 0-23
- rsp_mm  out  8  minutes 0-59
- rsp_ss  out  8  seconds 0-59
- rsp_DD  out  8  day of month 1-31
- rsp_MM  out  8  month 1-12
- rsp_YYYY  out  16  year
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async on rst_n low; takes effect immediately, including mid-operation):
  - state=IDLE, req_ready=0, rsp_valid=0, all rsp_* fields=0, conv_t=0, busy=0.
  - last_grant=1, so requester 0 wins the first contest.
  - An in-flight result is discarded and never presented.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: grant = rr_arbiter_2(req_valid, last_grant); req_ready=grant, else 0.
  - On grant: register conv_t <= req_t[g], owner <= g, last_grant <= g, lat_cnt <= CONV_LAT-1, go to WAIT.
  - No requests: stay in IDLE.
- Round-robin rule:
  - Both valid: grant the index != last_grant.
  - Single valid: grant it regardless of last_grant.
- WAIT:
  - The converter is driven from conv_t. Outputs pass through CONV_LAT-1 pipeline stages, then the capture register.
  - When lat_cnt==0: capture all six fields into the rsp_* registers, set rsp_valid[owner]=1, go to RESP.
  - Otherwise decrement lat_cnt.
- RESP:
  - Hold rsp_valid and all rsp_* fields stable.
  - When rsp_ready[owner]=1: clear rsp_valid and go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency:
  - Accept edge A (req_valid&req_ready); rsp_valid rises CONV_LAT+1 cycles after A (2 cycles at the default).
  - Minimum accept-to-accept spacing is CONV_LAT+2 cycles with rsp_ready held high.
- Requester rules:
  - Requesters hold req_valid and req_t stable until req_ready.
  - A requester may deassert req_valid before being granted; the block has no memory of withdrawn requests.
- Back-pressure:
  - A stalled rsp_ready blocks both requesters; req_ready stays 0 outside IDLE.
- Simultaneous events: a request arriving in the same cycle as RESP completion waits one cycle (IDLE grant); there is no bypass.
- Width rules:
  - Converter fields are zero-extended into 8/16-bit outputs.
  - conv_t is the full 32 bits, treated as unsigned with no range check.

Decomposition:
- Package time_conv_pkg:
  - NREQ=2, T_W=32, FIELD_W=8, YEAR_W=16.
  - State encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- Sub-module rr_arbiter_2: combinational 2-way round-robin; inputs req[1:0] and last; output one-hot grant[1:0].
- binary_time_converter is instantiated inside, unmodified.

Test Plan:
- Reset release, req_valid=01, req_t[31:0]=0, rsp_ready=11 -> req_ready=01 in the first IDLE cycle; rsp_valid=01 two cycles later with 0:0:0 1/1/1970.
- Requester 1, t=86401 -> rsp_valid=10 with 0:0:1 2/1/1970. Then t=951782400 -> 0:0:0 29/2/2000 (leap day).
- Both requesters valid continuously, t0=0, t1=3661 -> grants alternate 01,10,01,10. Requester 1 always gets 1:1:1 1/1/1970. Accepts are spaced 3 cycles apart.
- Owner 0 holds rsp_ready=0 for 5 cycles -> rsp_valid=01 and the fields stay stable; req_ready=00 throughout; request 1 is granted on the cycle after the handshake.
- Assert rst_n=0 during WAIT -> all outputs 0 immediately, no rsp_valid after release. The next simultaneous request is granted to requester 0.
- CONV_LAT=3 build, single request -> rsp_valid rises exactly 4 cycles after accept.
